// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU.
// ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties).
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [3:0]         req0_func,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [3:0]         req1_func,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic [SHAMT_W-1:0] req1_shamt,
  output logic [WIDTH-1:0]   alu_in1,
  output logic [WIDTH-1:0]   alu_in2,
  output logic [SHAMT_W-1:0] alu_shamt,
  output logic [3:0]         alu_func,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic [2:0]         alu_flags,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_out,
  output logic [2:0]         rsp_flags,
  output logic               rsp_err,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state, state_nx;
  logic   prio1;
  logic   gnt0, gnt1, grant, bad_func;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign prio1 = 1'b0;
`else
  // prio1 set: requester 1 wins the next tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prio1 <= 1'b0;
    else if (grant)
      prio1 <= gnt0;
  end
`endif

  assign gnt0 = req0_valid & (~req1_valid | ~prio1);
  assign gnt1 = req1_valid & (~req0_valid | prio1);

  assign grant      = (state == IDLE) & ~rst & (gnt0 | gnt1);
  assign req0_ready = (state == IDLE) & ~rst & gnt0;
  assign req1_ready = (state == IDLE) & ~rst & gnt1;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);
  assign bad_func   = (alu_func > 4'd8);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (gnt0 | gnt1) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_shamt <= '0;
      alu_func  <= '0;
      rsp_id    <= 1'b0;
      rsp_out   <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (grant) begin
        alu_in1   <= gnt1 ? req1_a : req0_a;
        alu_in2   <= gnt1 ? req1_b : req0_b;
        alu_shamt <= gnt1 ? req1_shamt : req0_shamt;
        alu_func  <= gnt1 ? req1_func : req0_func;
        rsp_id    <= gnt1;
      end
      // undefined codes return a clean zero result
      if (state == EXEC) begin
        rsp_err   <= bad_func;
        rsp_out   <= bad_func ? '0 : alu_out;
        rsp_flags <= bad_func ? '0 : alu_flags;
      end
    end
  end

endmodule
